// File: rtl/text_uart_pkg.sv
// Shared definitions for the text UART peripheral: register offsets,
// STATUS bit positions and the transmitter state encoding.
package text_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_NONEMPTY = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/text_fifo.sv
// Byte FIFO between the bus write port and the UART transmitter.
// The head entry is readable combinationally so it can be popped and used in the same cycle.
module text_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/text_uart_tx.sv
// Memory-mapped text output: bus byte writes are queued in a FIFO and
// shifted out as 8N1 frames, with a STATUS register for polling.
module text_uart_tx
    import text_uart_pkg::*;
#(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int          CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

    tx_state_t r_state;
    tx_state_t w_state_next;
    logic [15:0] r_baud;
    logic [15:0] w_baud_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        w_pop;
    logic        w_tx;
    logic        w_baud_done;

    logic        w_is_data_wr;
    logic        w_is_read;
    logic        w_push;
    logic        w_busy;
    logic [7:0]  w_fifo_rdata;
    logic        w_empty;
    logic        w_full;
    logic [CW-1:0] w_count;
    logic [31:0] w_status;
    logic        w_unused;

    text_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (wdata[7:0]),
        .rdata (w_fifo_rdata),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Only byte pushes can be back-pressured; everything else completes at once.
    assign w_is_data_wr = (address[3:2] == REG_DATA) && wstrobe[0];
    assign w_is_read    = (wstrobe == 4'b0000);
    assign ready        = reset && valid && !(w_is_data_wr && w_full);
    assign w_push       = ready && w_is_data_wr;
    assign w_busy       = (r_state != IDLE);

    always_comb begin
        w_status                = '0;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_BUSY]     = w_busy;
        w_status[STAT_NONEMPTY] = !w_empty;
    end

    assign rdata = (ready && w_is_read && (address[3:2] == REG_STATUS)) ? w_status : 32'd0;

    assign w_unused = ^{address[31:4], address[1:0], wdata[31:8], w_count};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
        end
    end

    assign w_baud_done = (r_baud == 16'd0);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx         = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_rdata;
                    w_baud_next  = BAUD_RELOAD;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_baud_done) begin
                    w_baud_next  = BAUD_RELOAD;
                    w_bit_next   = 3'd0;
                    w_state_next = DATA;
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            DATA: begin
                w_tx = r_shift[0];
                if (w_baud_done) begin
                    w_baud_next  = BAUD_RELOAD;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            STOP: begin
                w_tx = 1'b1;
                if (w_baud_done) begin
                    // Chain straight into the next frame when more text is queued.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_rdata;
                        w_baud_next  = BAUD_RELOAD;
                        w_state_next = START;
                    end else begin
                        w_baud_next  = 16'd0;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign tx = w_tx;

endmodule

// File: tb/tb_text_uart_tx.sv
// Bench for text_uart_tx: bus-level stimulus with random bytes, a serial-line
// decoder and frame-timing model derived from the 8N1 framing rules.
module tb_text_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;
    localparam int HIST  = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] address = 32'd0;
    logic [3:0]  wstrobe = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;

    text_uart_tx #(
        .DIVISOR    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .ready   (ready),
        .address (address),
        .wstrobe (wstrobe),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic tx_hist [HIST];

    logic [7:0] rx_q[$];
    logic       stop_q[$];
    int         start_q[$];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Serial decoder: samples the line in the middle of every bit period.
    initial begin : decoder
        int         phase;
        int         idx;
        logic [7:0] dbyte;
        logic       dstop;
        phase = -1;
        dbyte = 8'd0;
        dstop = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (cyc < HIST) tx_hist[cyc] = tx;
            if (!reset) begin
                phase = -1;
            end else if (phase < 0) begin
                if (tx === 1'b0) begin
                    phase = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                phase = phase + 1;
                if (phase % DIV == DIV / 2) begin
                    idx = phase / DIV;
                    if (idx >= 1 && idx <= 8) dbyte[idx-1] = tx;
                    if (idx == 9) dstop = tx;
                end
                if (phase == FRAME - 1) begin
                    rx_q.push_back(dbyte);
                    stop_q.push_back(dstop);
                    phase = -1;
                end
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic clear_capture();
        rx_q.delete();
        stop_q.delete();
        start_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic bus_write(input logic [1:0] reg_idx, input logic [3:0] strb,
                             input logic [7:0] data, output int edge_cyc, output int stall);
        address  = {28'd0, reg_idx, 2'b00};
        wstrobe  = strb;
        wdata    = ($urandom & 32'hFFFF_FF00) | {24'd0, data};
        valid    = 1'b1;
        stall    = 0;
        edge_cyc = -1;
        #1;
        while (ready !== 1'b1 && stall < 200) begin
            @(posedge clk);
            #2;
            stall++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: ready=%b after %0d cycles, required 1", ready, stall);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            edge_cyc = cyc;
        end
        valid   = 1'b0;
        wstrobe = 4'd0;
        $display("write reg=%0d strb=%b data=%02h edge=%0d stall=%0d", reg_idx, strb, data, edge_cyc, stall);
    endtask

    task automatic bus_read(input logic [1:0] reg_idx, output logic [31:0] val, output logic rdy);
        address = {28'd0, reg_idx, 2'b00};
        wstrobe = 4'd0;
        valid   = 1'b1;
        #1;
        rdy = ready;
        val = rdata;
        @(posedge clk);
        #1;
        valid = 1'b0;
        $display("read  reg=%0d data=%08h ready=%b cyc=%0d", reg_idx, val, rdy, cyc);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        r;
        address = 32'd4;
        wstrobe = 4'd0;
        valid   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++;
        if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %08h want 00000000", rdata); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        valid = 1'b0;
        reset = 1'b1;
        wait_cycles(2);
        bus_read(2'd1, v, r);
        checks++;
        if (r !== 1'b1 || v !== 32'h1) begin
            errors++;
            $display("FAIL reset_status: got ready=%b data=%08h want ready=1 data=00000001", r, v);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] bytes [2];
        int n;
        int st;
        int c;
        int ones;
        bytes[0] = 8'h41;
        bytes[1] = 8'($urandom);
        for (int t = 0; t < 2; t++) begin
            clear_capture();
            bus_write(2'd0, 4'b0001, bytes[t], n, st);
            checks++;
            if (st !== 0) begin errors++; $display("FAIL single_ready_same_cycle: stall=%0d want 0", st); end
            wait_cycles(FRAME + 10);
            checks++;
            if (tx_hist[n] !== 1'b1) begin errors++; $display("FAIL single_tx_before_pop: got %b want 1", tx_hist[n]); end
            for (int k = 0; k < 10; k++) begin
                c = n + 1 + DIV * k;
                checks++;
                if (tx_hist[c] !== frame_bit(bytes[t], k)) begin
                    errors++;
                    $display("FAIL single_bit%0d_first: byte=%02h got %b want %b", k, bytes[t], tx_hist[c], frame_bit(bytes[t], k));
                end
                checks++;
                if (tx_hist[c+DIV-1] !== frame_bit(bytes[t], k)) begin
                    errors++;
                    $display("FAIL single_bit%0d_last: byte=%02h got %b want %b", k, bytes[t], tx_hist[c+DIV-1], frame_bit(bytes[t], k));
                end
            end
            ones = 0;
            for (int k = n + 1 + FRAME; k < n + FRAME + 9; k++) ones += (tx_hist[k] === 1'b1) ? 1 : 0;
            checks++;
            if (ones !== 8) begin errors++; $display("FAIL single_idle_after: high cycles=%0d want 8", ones); end
            checks++;
            if (rx_q.size() !== 1 || start_q.size() !== 1) begin
                errors++;
                $display("FAIL single_frame_count: frames=%0d starts=%0d want 1", rx_q.size(), start_q.size());
            end else begin
                checks++;
                if (rx_q[0] !== bytes[t] || stop_q[0] !== 1'b1 || start_q[0] !== n + 1) begin
                    errors++;
                    $display("FAIL single_decode: byte=%02h stop=%b start=%0d want byte=%02h stop=1 start=%0d",
                             rx_q[0], stop_q[0], start_q[0], bytes[t], n + 1);
                end
            end
        end
    endtask

    task automatic test_status();
        logic [31:0] v;
        logic        r;
        int n;
        int st;
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL status_idle: got %08h want 00000001", v); end
        bus_write(2'd0, 4'b0001, 8'($urandom), n, st);
        wait_cycles(5);
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL status_in_frame: got %08h want 00000005", v); end
        bus_read(2'd2, v, r);
        checks++;
        if (r !== 1'b1 || v !== 32'h0) begin errors++; $display("FAIL read_reg2: ready=%b data=%08h want 1/00000000", r, v); end
        bus_read(2'd0, v, r);
        checks++;
        if (r !== 1'b1 || v !== 32'h0) begin errors++; $display("FAIL read_data_reg: ready=%b data=%08h want 1/00000000", r, v); end
        wait_cycles(FRAME);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0;
        logic [7:0] b1;
        int n0;
        int n1;
        int st;
        int ones;
        int bad;
        logic exp_busy;
        clear_capture();
        b0 = 8'h55;
        b1 = 8'hAA;
        bus_write(2'd0, 4'b0001, b0, n0, st);
        bus_write(2'd0, 4'b0001, b1, n1, st);
        checks++;
        if (n1 !== n0 + 1) begin errors++; $display("FAIL b2b_accept: second edge=%0d want %0d", n1, n0 + 1); end
        address = 32'd4;
        wstrobe = 4'd0;
        valid   = 1'b1;
        ones = 0;
        bad  = 0;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            #1;
            exp_busy = (cyc >= n0 + 1) && (cyc < n0 + 1 + 2 * FRAME);
            if (rdata[2] === 1'b1) ones++;
            if (rdata[2] !== exp_busy) bad++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL b2b_busy_profile: mismatching cycles=%0d want 0", bad); end
        checks++;
        if (ones !== 2 * FRAME) begin errors++; $display("FAIL b2b_busy_length: got %0d want %0d", ones, 2 * FRAME); end
        checks++;
        if (rx_q.size() !== 2 || start_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_frame_count: got %0d want 2", rx_q.size());
        end else begin
            checks++;
            if (start_q[1] - start_q[0] !== FRAME) begin
                errors++;
                $display("FAIL b2b_gap: start spacing=%0d want %0d", start_q[1] - start_q[0], FRAME);
            end
            checks++;
            if (rx_q[0] !== b0 || rx_q[1] !== b1 || stop_q[0] !== 1'b1 || stop_q[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_decode: got %02h %02h want %02h %02h", rx_q[0], rx_q[1], b0, b1);
            end
        end
    endtask

    task automatic test_fill();
        logic [7:0] wq[$];
        logic [7:0] b;
        logic [31:0] v;
        logic r;
        int n;
        int first;
        int st;
        int gaps;
        clear_capture();
        for (int k = 0; k <= DEPTH; k++) begin
            b = 8'($urandom);
            wq.push_back(b);
            bus_write(2'd0, 4'b0001, b, n, st);
            if (k == 0) first = n;
            checks++;
            if (st !== 0 || n !== first + k) begin
                errors++;
                $display("FAIL fill_accept%0d: stall=%0d edge=%0d want 0/%0d", k, st, n, first + k);
            end
        end
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'hE) begin errors++; $display("FAIL fill_status_full: got %08h want 0000000e", v); end
        b = 8'($urandom);
        wq.push_back(b);
        bus_write(2'd0, 4'b0001, b, n, st);
        checks++;
        if (n !== first + 1 + FRAME + 1) begin
            errors++;
            $display("FAIL fill_backpressure_release: edge=%0d want %0d", n, first + 1 + FRAME + 1);
        end
        wait_cycles(wq.size() * FRAME + 10);
        checks++;
        if (rx_q.size() !== wq.size()) begin
            errors++;
            $display("FAIL fill_frame_count: got %0d want %0d", rx_q.size(), wq.size());
        end else begin
            for (int i = 0; i < wq.size(); i++) begin
                checks++;
                if (rx_q[i] !== wq[i] || stop_q[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_byte%0d: got %02h stop=%b want %02h stop=1", i, rx_q[i], stop_q[i], wq[i]);
                end
            end
            gaps = 0;
            for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != FRAME) gaps++;
            checks++;
            if (gaps !== 0 || start_q[0] !== first + 1) begin
                errors++;
                $display("FAIL fill_timing: irregular gaps=%0d first start=%0d want 0/%0d", gaps, start_q[0], first + 1);
            end
        end
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL fill_drained_status: got %08h want 00000001", v); end
    endtask

    task automatic test_no_push();
        logic [31:0] v;
        logic r;
        int n;
        int st;
        int ones;
        clear_capture();
        bus_write(2'd0, 4'b0010, 8'($urandom), n, st);
        checks++;
        if (st !== 0) begin errors++; $display("FAIL nopush_ready: stall=%0d want 0", st); end
        bus_write(2'd2, 4'b1111, 8'($urandom), n, st);
        bus_write(2'd3, 4'b0001, 8'($urandom), n, st);
        checks++;
        if (st !== 0) begin errors++; $display("FAIL ignored_reg_ready: stall=%0d want 0", st); end
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL nopush_status: got %08h want 00000001", v); end
        wait_cycles(FRAME);
        ones = 0;
        for (int k = n; k < n + FRAME; k++) ones += (tx_hist[k] === 1'b1) ? 1 : 0;
        checks++;
        if (ones !== FRAME || start_q.size() !== 0) begin
            errors++;
            $display("FAIL nopush_line_idle: high cycles=%0d frames=%0d want %0d/0", ones, start_q.size(), FRAME);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic [31:0] v;
        logic r;
        int n0;
        int n;
        int st;
        int ones;
        b = 8'($urandom) & 8'hF7;
        bus_write(2'd0, 4'b0001, b, n0, st);
        for (int i = 0; i < 3; i++) bus_write(2'd0, 4'b0001, 8'($urandom), n, st);
        wait_cycles((n0 + 1 + DIV * 4 + 1) - cyc);
        address = 32'd4;
        wstrobe = 4'd0;
        valid   = 1'b1;
        #2;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3_low: got %b want 0", tx); end
        clear_capture();
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL midframe_async_reset: tx=%b ready=%b rdata=%08h want 1/0/00000000", tx, ready, rdata);
        end
        repeat (2) @(posedge clk);
        #3;
        valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        bus_read(2'd1, v, r);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL midframe_status_after: got %08h want 00000001", v); end
        wait_cycles(2 * FRAME);
        ones = 0;
        for (int k = n; k < n + 2 * FRAME; k++) ones += (tx_hist[k] === 1'b1) ? 1 : 0;
        checks++;
        if (ones !== 2 * FRAME || rx_q.size() !== 0 || start_q.size() !== 0) begin
            errors++;
            $display("FAIL midframe_no_more_frames: high cycles=%0d frames=%0d want %0d/0", ones, start_q.size(), 2 * FRAME);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_status();
        test_back_to_back();
        test_fill();
        test_no_push();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
